// File: rtl/mult_pkg.sv
// Shared types and constants for the time-shared 8x8 multiplier.
// MULT_SEQ_ZERO_SKIP_EN enables the step-scan helper used by zero-skip.
package mult_pkg;

    localparam int IN_W  = 8;
    localparam int SUB_W = 4;
    localparam int OUT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    typedef logic [1:0] step_t;

    localparam int unsigned SHIFT_AMT [4] = '{0, 4, 4, 8};

`ifdef MULT_SEQ_ZERO_SKIP_EN
    // {found, index} of the lowest set bit of m
    function automatic logic [2:0] first_set(input logic [3:0] m);
        logic [2:0] r;
        r = '0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction
`endif

endpackage

// File: rtl/mult8_seq_share_ctrl_if.sv
// Operand/product valid-ready bundle for the sequential multiplier.
// Same bundle with or without MULT_SEQ_ZERO_SKIP_EN.
interface mult8_seq_share_ctrl_if;
    import mult_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  A;
    logic [IN_W-1:0]  B;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] P;
    logic             busy;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, P, busy
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, P, busy
    );

endinterface

// File: rtl/mult4_core.sv
// Combinational 4x4 -> 8 unsigned multiplier core.
// Shared by all partial products; unaffected by MULT_SEQ_ZERO_SKIP_EN.
module mult4_core
    import mult_pkg::*;
(
    input  logic [SUB_W-1:0]   a,
    input  logic [SUB_W-1:0]   b,
    output logic [2*SUB_W-1:0] p
);

    assign p = {{SUB_W{1'b0}}, a} * {{SUB_W{1'b0}}, b};

endmodule

// File: rtl/mult8_seq_share_ctrl.sv
// 8x8 multiplier sequencing four nibble products through one core.
// MULT_SEQ_ZERO_SKIP_EN skips steps whose nibble product is zero.
module mult8_seq_share_ctrl
    import mult_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    mult8_seq_share_ctrl_if.slave bus
);

    state_t           state_q, state_d;
    step_t            step_q, step_d;
    logic [IN_W-1:0]  a_q, a_d;
    logic [IN_W-1:0]  b_q, b_d;
    logic [OUT_W-1:0] acc_q, acc_d;

    logic [SUB_W-1:0]   a_nib, b_nib;
    logic [2*SUB_W-1:0] core_p;
    logic [OUT_W-1:0]   term;
    logic               accept;
    logic               out_fire;

`ifdef MULT_SEQ_ZERO_SKIP_EN
    logic [3:0] mask_q, mask_d;
    logic [3:0] mask_in, mask_left;
    logic [2:0] first_in, next_left;
    logic       alo_nz, ahi_nz, blo_nz, bhi_nz;

    assign alo_nz = |bus.A[SUB_W-1:0];
    assign ahi_nz = |bus.A[IN_W-1:SUB_W];
    assign blo_nz = |bus.B[SUB_W-1:0];
    assign bhi_nz = |bus.B[IN_W-1:SUB_W];

    assign mask_in   = {ahi_nz && bhi_nz,
                        ahi_nz && blo_nz,
                        alo_nz && bhi_nz,
                        alo_nz && blo_nz};
    assign mask_left = mask_q & ~(4'b0001 << step_q);
    assign first_in  = first_set(mask_in);
    assign next_left = first_set(mask_left);
`endif

    // step bit 1 picks the A nibble, bit 0 the B nibble
    assign a_nib = step_q[1] ? a_q[IN_W-1:SUB_W] : a_q[SUB_W-1:0];
    assign b_nib = step_q[0] ? b_q[IN_W-1:SUB_W] : b_q[SUB_W-1:0];

    mult4_core u_core (
        .a (a_nib),
        .b (b_nib),
        .p (core_p)
    );

    assign term = OUT_W'(core_p) << SHIFT_AMT[step_q];

    assign accept   = bus.in_valid && bus.in_ready;
    assign out_fire = bus.out_valid && bus.out_ready;

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.P         = acc_q;
    assign bus.busy      = (state_q != IDLE);

    // next-state, step sequencing and accumulation
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
`ifdef MULT_SEQ_ZERO_SKIP_EN
        mask_d  = mask_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = MUL;
`ifdef MULT_SEQ_ZERO_SKIP_EN
                    mask_d  = mask_in;
                    step_d  = first_in[1:0];
                    if (!first_in[2]) state_d = DONE;
`endif
                end
            end
            MUL: begin
                acc_d = acc_q + term;
`ifdef MULT_SEQ_ZERO_SKIP_EN
                mask_d = mask_left;
                if (next_left[2]) step_d = next_left[1:0];
                else              state_d = DONE;
`else
                if (step_q == 2'd3) state_d = DONE;
                else                step_d  = step_q + 2'd1;
`endif
            end
            DONE: begin
                if (out_fire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // operand, step and accumulator registers
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
`ifdef MULT_SEQ_ZERO_SKIP_EN
            mask_q <= '0;
`endif
        end else begin
            step_q <= step_d;
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
`ifdef MULT_SEQ_ZERO_SKIP_EN
            mask_q <= mask_d;
`endif
        end
    end

endmodule
